// File: rtl/btn_pulse_pkg.sv
// btn_pulse shared definitions.
// Channel FSM state type and counter width helpers.
package btn_pulse_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DB_PRESS = 2'd1,
        HELD     = 2'd2,
        DB_REL   = 2'd3
    } state_t;

    // Bits needed to hold the value n (never less than one bit).
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_pulse_if.sv
// btn_pulse button/strobe bundle.
// slave = the button front end, master = whoever drives the pins.
interface btn_pulse_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0] btn_i;
    logic [N_CH-1:0] press_stb_o;
    logic [N_CH-1:0] release_stb_o;
    logic [N_CH-1:0] held_o;
    logic [N_CH-1:0] repeat_stb_o;
    logic            any_press_o;

    modport master (
        output btn_i,
        input  press_stb_o,
        input  release_stb_o,
        input  held_o,
        input  repeat_stb_o,
        input  any_press_o
    );

    modport slave (
        input  btn_i,
        output press_stb_o,
        output release_stb_o,
        output held_o,
        output repeat_stb_o,
        output any_press_o
    );
endinterface

// File: rtl/btn_pulse_ch.sv
// One button channel: 2-flop synchroniser, two-edge debounce FSM,
// press/release strobes, held level and auto-repeat ticks.
module btn_pulse_ch
    import btn_pulse_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 16,
    parameter int HOLD_CYC     = 1000,
    parameter int REPEAT_CYC   = 250
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press_stb,
    output logic release_stb,
    output logic held,
    output logic repeat_stb
);
    localparam int DW = cnt_w(DEBOUNCE_CYC);
    localparam int RW = cnt_w(max_of(HOLD_CYC, REPEAT_CYC));
    localparam bit REPEAT_EN = (REPEAT_CYC != 0);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYC - 1);
    localparam logic [RW-1:0] HOLD_LAST = RW'(HOLD_CYC - 1);
    localparam logic [RW-1:0] REP_LAST =
        RW'(REPEAT_EN ? REPEAT_CYC - 1 : 0);

    logic          sync1;
    logic          s;
    state_t        state;
    logic [DW-1:0] db_cnt;
    logic [RW-1:0] rep_cnt;
    logic          first;
    logic [RW-1:0] rep_last;

    // First repeat waits the hold time, later ones the repeat period.
    assign rep_last = first ? HOLD_LAST : REP_LAST;

    // Two-flop synchroniser; s is the only view of the button the FSM uses.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
        end else begin
            sync1 <= btn;
            s     <= sync1;
        end
    end

    // Debounce FSM with registered strobes; rep_cnt only runs in HELD.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            db_cnt      <= '0;
            rep_cnt     <= '0;
            first       <= 1'b0;
            press_stb   <= 1'b0;
            release_stb <= 1'b0;
            held        <= 1'b0;
            repeat_stb  <= 1'b0;
        end else begin
            press_stb   <= 1'b0;
            release_stb <= 1'b0;
            repeat_stb  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (s) begin
                        state  <= DB_PRESS;
                        db_cnt <= '0;
                    end
                end
                DB_PRESS: begin
                    if (!s) begin
                        state <= IDLE;
                    end else if (db_cnt == DB_LAST) begin
                        state     <= HELD;
                        press_stb <= 1'b1;
                        held      <= 1'b1;
                        rep_cnt   <= '0;
                        first     <= 1'b1;
                    end else begin
                        db_cnt <= db_cnt + DW'(1);
                    end
                end
                HELD: begin
                    if (!s) begin
                        state  <= DB_REL;
                        db_cnt <= '0;
                    end else if (REPEAT_EN && rep_cnt == rep_last) begin
                        repeat_stb <= 1'b1;
                        rep_cnt    <= '0;
                        first      <= 1'b0;
                    end else if (rep_cnt != '1) begin
                        rep_cnt <= rep_cnt + RW'(1);
                    end
                end
                DB_REL: begin
                    if (s) begin
                        state <= HELD;
                    end else if (db_cnt == DB_LAST) begin
                        state       <= IDLE;
                        release_stb <= 1'b1;
                        held        <= 1'b0;
                    end else begin
                        db_cnt <= db_cnt + DW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    held  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: rtl/btn_pulse.sv
// Multi-channel push-button front end.
// Independent btn_pulse_ch per channel plus a combined press flag.
module btn_pulse
    import btn_pulse_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int DEBOUNCE_CYC = 16,
    parameter int HOLD_CYC     = 1000,
    parameter int REPEAT_CYC   = 250
) (
    input  logic        clk_i,
    input  logic        rst_i,
    btn_pulse_if.slave  bus
);
    logic [N_CH-1:0] press;
    logic [N_CH-1:0] rel;
    logic [N_CH-1:0] held;
    logic [N_CH-1:0] rep;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        btn_pulse_ch #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .HOLD_CYC     (HOLD_CYC),
            .REPEAT_CYC   (REPEAT_CYC)
        ) u_ch (
            .clk         (clk_i),
            .rst         (rst_i),
            .btn         (bus.btn_i[g]),
            .press_stb   (press[g]),
            .release_stb (rel[g]),
            .held        (held[g]),
            .repeat_stb  (rep[g])
        );
    end

    assign bus.press_stb_o   = press;
    assign bus.release_stb_o = rel;
    assign bus.held_o        = held;
    assign bus.repeat_stb_o  = rep;
    assign bus.any_press_o   = |press;
endmodule
